// File: rtl/pio_debounced_irq_if.sv
// pio_debounced_irq_if
//   Avalon-MM slave bus bundle for the parallel I/O peripheral.
//   master : drives address/chipselect/read/write/writedata, samples readdata
//   slave  : the peripheral side of the same signals
//   address    [2:0]  word address
//   chipselect        slave select
//   read / write      access strobes, qualified by chipselect
//   writedata  [31:0] write data
//   readdata   [31:0] registered read data, valid the cycle after the strobe
interface pio_debounced_irq_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output read,
        output write,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  read,
        input  write,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/pio_debounced_irq.sv
// pio_debounced_irq
//   Parametrised Avalon-MM parallel I/O block for the HPS lightweight bridge.
//   Input path : SYNC_STAGES synchroniser -> per-bit debounce -> edge detect
//                -> sticky edge capture -> masked, registered level interrupt.
//   Output path: data register with atomic set/clear aliases, drives pio_out.
//   Ports:
//     clk      system clock
//     reset_n  asynchronous active-low reset
//     bus      Avalon-MM slave (address/chipselect/read/write/writedata/readdata)
//     irq      level interrupt, active high, registered
//     pio_in   asynchronous external inputs
//     pio_out  external outputs, straight from the output register
//   Register map (word address):
//     0 DATA_IN  RO   debounced inputs
//     1 DATA_OUT RW   output register
//     2 OUT_SET  WO   out |= wdata  (reads 0)
//     3 OUT_CLR  WO   out &= ~wdata (reads 0)
//     4 IRQ_MASK RW
//     5 EDGE_CAP RW1C
//     6 RISE_EN  RW
//     7 FALL_EN  RW
module pio_debounced_irq #(
    parameter int unsigned          IN_WIDTH        = 10,
    parameter int unsigned          OUT_WIDTH       = 10,
    parameter int unsigned          DEBOUNCE_CYCLES = 50000,
    parameter int unsigned          SYNC_STAGES     = 2,
    parameter logic [OUT_WIDTH-1:0] OUT_RESET       = '0
) (
    input  logic                 clk,
    input  logic                 reset_n,
    pio_debounced_irq_if.slave   bus,
    output logic                 irq,
    input  logic [IN_WIDTH-1:0]  pio_in,
    output logic [OUT_WIDTH-1:0] pio_out
);

    typedef enum logic [2:0] {
        A_DATA_IN  = 3'd0,
        A_DATA_OUT = 3'd1,
        A_OUT_SET  = 3'd2,
        A_OUT_CLR  = 3'd3,
        A_IRQ_MASK = 3'd4,
        A_EDGE_CAP = 3'd5,
        A_RISE_EN  = 3'd6,
        A_FALL_EN  = 3'd7
    } reg_addr_e;

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    reg_addr_e             addr;
    logic                  wr_en;
    logic                  rd_en;
    logic [IN_WIDTH-1:0]   wdata_in;
    logic [OUT_WIDTH-1:0]  wdata_out;

    assign addr      = reg_addr_e'(bus.address);
    assign wr_en     = bus.chipselect & bus.write;
    assign rd_en     = bus.chipselect & bus.read;
    assign wdata_in  = bus.writedata[IN_WIDTH-1:0];
    assign wdata_out = bus.writedata[OUT_WIDTH-1:0];

    // ------------------------------------------------------------------
    // Synchroniser
    // ------------------------------------------------------------------
    logic [IN_WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [IN_WIDTH-1:0] sync_in;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
        end else begin
            sync_q[0] <= pio_in;
            for (int unsigned s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    assign sync_in = sync_q[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Debounce
    // ------------------------------------------------------------------
    logic [IN_WIDTH-1:0] stable_q;

    if (DEBOUNCE_CYCLES == 0) begin : g_bypass
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                stable_q <= '0;
            end else begin
                stable_q <= sync_in;
            end
        end
    end else begin : g_debounce
        localparam int unsigned       CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
        localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

        logic [CNT_W-1:0] cnt_q [IN_WIDTH];

        // The counter only runs while the synchronised pin disagrees with the
        // accepted value; any return to agreement restarts qualification.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                stable_q <= '0;
                for (int unsigned i = 0; i < IN_WIDTH; i++) begin
                    cnt_q[i] <= '0;
                end
            end else begin
                for (int unsigned i = 0; i < IN_WIDTH; i++) begin
                    if (sync_in[i] == stable_q[i]) begin
                        cnt_q[i] <= '0;
                    end else if (cnt_q[i] == CNT_LAST) begin
                        stable_q[i] <= sync_in[i];
                        cnt_q[i]    <= '0;
                    end else begin
                        cnt_q[i] <= cnt_q[i] + CNT_W'(1);
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Edge detect, capture and control registers
    // ------------------------------------------------------------------
    logic [IN_WIDTH-1:0]  stable_d_q;
    logic [IN_WIDTH-1:0]  rise;
    logic [IN_WIDTH-1:0]  fall;

    logic [IN_WIDTH-1:0]  edge_cap_q, edge_cap_d;
    logic [IN_WIDTH-1:0]  mask_q,     mask_d;
    logic [IN_WIDTH-1:0]  rise_en_q,  rise_en_d;
    logic [IN_WIDTH-1:0]  fall_en_q,  fall_en_d;
    logic [OUT_WIDTH-1:0] out_q,      out_d;
    logic [31:0]          rdata_q,    rdata_d;
    logic                 irq_q,      irq_d;

    assign rise = stable_q  & ~stable_d_q & rise_en_q;
    assign fall = ~stable_q &  stable_d_q & fall_en_q;

    always_comb begin
        out_d     = out_q;
        mask_d    = mask_q;
        rise_en_d = rise_en_q;
        fall_en_d = fall_en_q;

        edge_cap_d = edge_cap_q;
        if (wr_en) begin
            unique case (addr)
                A_DATA_OUT: out_d      = wdata_out;
                A_OUT_SET:  out_d      = out_q | wdata_out;
                A_OUT_CLR:  out_d      = out_q & ~wdata_out;
                A_IRQ_MASK: mask_d     = wdata_in;
                A_EDGE_CAP: edge_cap_d = edge_cap_q & ~wdata_in;
                A_RISE_EN:  rise_en_d  = wdata_in;
                A_FALL_EN:  fall_en_d  = wdata_in;
                default: ;
            endcase
        end
        // New events are merged after the W1C so a same-cycle event survives.
        edge_cap_d = edge_cap_d | rise | fall;

        // Interrupt is taken from the registered capture/mask state, so it
        // trails any change to either by one cycle.
        irq_d = |(edge_cap_q & mask_q);
    end

    always_comb begin
        rdata_d = rdata_q;
        if (rd_en) begin
            unique case (addr)
                A_DATA_IN:  rdata_d = 32'(stable_q);
                A_DATA_OUT: rdata_d = 32'(out_q);
                A_OUT_SET:  rdata_d = '0;
                A_OUT_CLR:  rdata_d = '0;
                A_IRQ_MASK: rdata_d = 32'(mask_q);
                A_EDGE_CAP: rdata_d = 32'(edge_cap_q);
                A_RISE_EN:  rdata_d = 32'(rise_en_q);
                A_FALL_EN:  rdata_d = 32'(fall_en_q);
                default:    rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stable_d_q <= '0;
            edge_cap_q <= '0;
            mask_q     <= '0;
            rise_en_q  <= '0;
            fall_en_q  <= '0;
            out_q      <= OUT_RESET;
            rdata_q    <= '0;
            irq_q      <= 1'b0;
        end else begin
            stable_d_q <= stable_q;
            edge_cap_q <= edge_cap_d;
            mask_q     <= mask_d;
            rise_en_q  <= rise_en_d;
            fall_en_q  <= fall_en_d;
            out_q      <= out_d;
            rdata_q    <= rdata_d;
            irq_q      <= irq_d;
        end
    end

    assign pio_out      = out_q;
    assign irq          = irq_q;
    assign bus.readdata = rdata_q;

endmodule

// File: tb/tb_pio_debounced_irq.sv
module tb_pio_debounced_irq;

    localparam int unsigned IN_W   = 10;
    localparam int unsigned OUT_W  = 10;
    localparam int unsigned DEB    = 8;
    localparam int unsigned SYNC   = 2;
    localparam int unsigned LAT    = SYNC + DEB;
    localparam int unsigned LAT_BP = SYNC + 1;
    localparam logic [OUT_W-1:0] OUT_RST = 10'h155;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #10 clk = ~clk;

    logic [IN_W-1:0]  pio_in, pio_in_bp;
    logic [OUT_W-1:0] pio_out, pio_out_bp;
    logic             irq, irq_bp;

    pio_debounced_irq_if bif ();
    pio_debounced_irq_if bif_bp ();

    pio_debounced_irq #(
        .IN_WIDTH(IN_W), .OUT_WIDTH(OUT_W), .DEBOUNCE_CYCLES(DEB),
        .SYNC_STAGES(SYNC), .OUT_RESET(OUT_RST)
    ) dut (
        .clk(clk), .reset_n(reset_n), .bus(bif), .irq(irq),
        .pio_in(pio_in), .pio_out(pio_out)
    );

    pio_debounced_irq #(
        .IN_WIDTH(IN_W), .OUT_WIDTH(OUT_W), .DEBOUNCE_CYCLES(0),
        .SYNC_STAGES(SYNC), .OUT_RESET('0)
    ) dut_bp (
        .clk(clk), .reset_n(reset_n), .bus(bif_bp), .irq(irq_bp),
        .pio_in(pio_in_bp), .pio_out(pio_out_bp)
    );

    int unsigned checks   = 0;
    int unsigned failures = 0;

    logic [31:0] exp_q [$];
    string       tag_q [$];
    logic [OUT_W-1:0] out_model;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_idle();
        bif.chipselect = 1'b0;
        bif.read       = 1'b0;
        bif.write      = 1'b0;
        bif.address    = '0;
        bif.writedata  = '0;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        bif.chipselect = 1'b1;
        bif.write      = 1'b1;
        bif.read       = 1'b0;
        bif.address    = a;
        bif.writedata  = d;
        tick();
        bus_idle();
    endtask

    task automatic start_poll(input logic [2:0] a);
        bif.chipselect = 1'b1;
        bif.read       = 1'b1;
        bif.write      = 1'b0;
        bif.address    = a;
    endtask

    task automatic sb_push(input logic [31:0] exp, input string tag);
        exp_q.push_back(exp);
        tag_q.push_back(tag);
    endtask

    task automatic sb_check(input logic [31:0] got);
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL scoreboard_empty observed=%0h expected=none", got);
        end else begin
            check(tag_q.pop_front(), got, exp_q.pop_front());
        end
    endtask

    // One polling cycle on the main DUT with the read strobe already held.
    task automatic poll_step(input logic [31:0] exp, input string tag);
        sb_push(exp, tag);
        tick();
        sb_check(bif.readdata);
    endtask

    task automatic rd_check(input logic [2:0] a, input logic [31:0] exp, input string tag);
        start_poll(a);
        poll_step(exp, tag);
        bus_idle();
    endtask

    initial begin
        pio_in    = '0;
        pio_in_bp = '0;
        bus_idle();
        bif_bp.chipselect = 1'b1;
        bif_bp.read       = 1'b1;
        bif_bp.write      = 1'b0;
        bif_bp.address    = 3'd0;
        bif_bp.writedata  = '0;

        // ---------------- reset values ----------------
        repeat (3) tick();
        reset_n = 1'b1;
        tick();
        wr(3'd1, 32'h2AA);
        wr(3'd4, 32'h3FF);
        wr(3'd6, 32'h3FF);
        check("out_before_rst", 32'(pio_out), 32'h2AA);
        start_poll(3'd4);
        tick();
        bus_idle();
        #5;
        reset_n = 1'b0;
        #1;
        check("rst_async_pio_out", 32'(pio_out), 32'(OUT_RST));
        check("rst_async_irq", 32'(irq), 32'h0);
        check("rst_async_readdata", bif.readdata, 32'h0);
        tick();
        reset_n = 1'b1;
        tick();

        start_poll(3'd1);
        #5;
        check("rd_latency_pre", bif.readdata, 32'h0);
        @(posedge clk);
        #1;
        check("rd_latency_post", bif.readdata, 32'(OUT_RST));
        bus_idle();
        tick();
        check("rd_hold", bif.readdata, 32'(OUT_RST));
        for (int a = 0; a < 8; a++) begin
            rd_check(3'(a), (a == 1) ? 32'(OUT_RST) : 32'h0, "rst_reg");
        end
        check("rst_irq", 32'(irq), 32'h0);

        // ---------------- debounce qualification ----------------
        start_poll(3'd0);
        pio_in[0] = 1'b1;
        for (int k = 1; k <= 7; k++) poll_step(32'h0, "glitch_pulse");
        pio_in[0] = 1'b0;
        for (int k = 1; k <= 15; k++) poll_step(32'h0, "glitch_after");

        pio_in[0] = 1'b1;
        for (int k = 1; k <= int'(LAT) + 1; k++) begin
            poll_step((k <= int'(LAT)) ? 32'h0 : 32'h1, "deb_qualify");
            if (k == int'(DEB)) pio_in[0] = 1'b0;
        end
        bus_idle();
        repeat (LAT + 4) tick();
        rd_check(3'd0, 32'h0, "deb_fall");

        // ---------------- output set/clear ----------------
        out_model = 10'h0F0;
        wr(3'd1, 32'h0F0);
        check("out_write", 32'(pio_out), 32'(out_model));
        out_model = out_model | 10'h003;
        wr(3'd2, 32'h003);
        check("out_set", 32'(pio_out), 32'(out_model));
        out_model = out_model & ~10'h030;
        wr(3'd3, 32'h030);
        check("out_clr", 32'(pio_out), 32'(out_model));
        rd_check(3'd1, 32'(out_model), "rd_data_out");
        rd_check(3'd2, 32'h0, "rd_out_set");
        rd_check(3'd3, 32'h0, "rd_out_clr");

        bif.chipselect = 1'b0;
        bif.write      = 1'b1;
        bif.address    = 3'd1;
        bif.writedata  = 32'h0;
        tick();
        bus_idle();
        check("cs_low_write", 32'(pio_out), 32'(out_model));
        bif.chipselect = 1'b0;
        bif.read       = 1'b1;
        bif.address    = 3'd1;
        tick();
        bus_idle();
        check("cs_low_read_hold", bif.readdata, 32'h0);

        // ---------------- edge capture and interrupt ----------------
        wr(3'd6, 32'h1);
        wr(3'd7, 32'h2);
        wr(3'd4, 32'h1);
        start_poll(3'd5);
        pio_in = 10'b11;
        for (int k = 1; k <= int'(LAT) + 2; k++) begin
            poll_step((k <= int'(LAT) + 1) ? 32'h0 : 32'h1, "edge_rise");
            check("irq_rise", 32'(irq), (k <= int'(LAT) + 1) ? 32'h0 : 32'h1);
        end
        pio_in = 10'b01;
        for (int k = 1; k <= int'(LAT) + 2; k++) begin
            poll_step((k <= int'(LAT) + 1) ? 32'h1 : 32'h3, "edge_fall");
            check("irq_hold", 32'(irq), 32'h1);
        end
        bus_idle();
        wr(3'd5, 32'h1);
        check("irq_w1c_lag", 32'(irq), 32'h1);
        rd_check(3'd5, 32'h2, "edge_w1c");
        check("irq_w1c_fall", 32'(irq), 32'h0);

        // ---------------- clear/event collision ----------------
        pio_in = '0;
        repeat (LAT + 2) tick();
        wr(3'd5, 32'h2);
        rd_check(3'd5, 32'h0, "edge_cleared");
        pio_in[0] = 1'b1;
        repeat (LAT) tick();
        wr(3'd5, 32'h1);
        rd_check(3'd5, 32'h1, "collision_event_wins");
        check("collision_irq", 32'(irq), 32'h1);
        wr(3'd6, 32'h0);
        wr(3'd7, 32'h0);
        rd_check(3'd5, 32'h1, "en_change_keeps_cap");

        // ---------------- debounce bypass ----------------
        pio_in_bp = 10'h008;
        for (int k = 1; k <= int'(LAT_BP) + 1; k++) begin
            sb_push((k <= int'(LAT_BP)) ? 32'h0 : 32'h8, "bypass_rise");
            tick();
            sb_check(bif_bp.readdata);
        end
        pio_in_bp = '0;
        for (int k = 1; k <= int'(LAT_BP) + 1; k++) begin
            sb_push((k <= int'(LAT_BP)) ? 32'h8 : 32'h0, "bypass_fall");
            tick();
            sb_check(bif_bp.readdata);
        end

        // ---------------- reset mid-debounce ----------------
        pio_in = '0;
        repeat (LAT + 2) tick();
        rd_check(3'd0, 32'h0, "pre_mid_rst");
        start_poll(3'd0);
        pio_in[0] = 1'b1;
        for (int k = 1; k <= int'(SYNC) + 5; k++) poll_step(32'h0, "mid_debounce");
        reset_n = 1'b0;
        #1;
        check("mid_rst_pio_out", 32'(pio_out), 32'(OUT_RST));
        tick();
        tick();
        reset_n = 1'b1;
        for (int k = 1; k <= int'(LAT) + 1; k++) begin
            poll_step((k <= int'(LAT)) ? 32'h0 : 32'h1, "rst_requalify");
        end
        bus_idle();

        check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pio_debounced_irq.md
Name: pio_debounced_irq

Overview:
- Generalised Avalon-MM parallel I/O peripheral for the FPGA side of the HPS lightweight bridge.
- Replaces the fixed LED/switch/key PIOs with one parametrised block.
- The input path has synchronisers, per-bit debounce, and rising/falling edge capture with a maskable interrupt.
- The output path has a data register plus atomic bit-set and bit-clear aliases.

Parameters:
- IN_WIDTH, 10: input bits (1-32).
- OUT_WIDTH, 10: output bits (1-32).
- DEBOUNCE_CYCLES, 50000: consecutive stable clk cycles needed to accept an input change. 0 bypasses debounce.
- SYNC_STAGES, 2: synchroniser flops per input bit (>=2).
- OUT_RESET, 0: reset value of the output register.

Ports:
- clk, input, 1: system clock (50 MHz).
- reset_n, input, 1: asynchronous active-low reset.
- address, input, 3: word address.
- chipselect, input, 1: slave select.
- read, input, 1: read strobe.
- write, input, 1: write strobe.
- writedata, input, 32: write data.
- readdata, output, 32: read data, registered.
- irq, output, 1: level interrupt, active high.
- pio_in, input, IN_WIDTH: asynchronous external inputs (switches, keys).
- pio_out, output, OUT_WIDTH: external outputs (LEDs).

Behaviour:
- Reset (async assert, sync release) clears every flop: synchronisers, debounce counters, stable[]=0, edge_cap=0, mask=0, rise_en=0, fall_en=0, readdata=0, irq=0, pio_out=OUT_RESET.
- Synchroniser: SYNC_STAGES flop chain per bit gives sync[i].
- Debounce, per bit i:
  - A counter of width clog2(DEBOUNCE_CYCLES+1) clears whenever sync[i]==stable[i].
  - Otherwise the counter increments each cycle.
  - When it reaches DEBOUNCE_CYCLES-1 while still differing, stable[i]<=sync[i] and the counter clears.
  - Net latency from pin change to stable: SYNC_STAGES+DEBOUNCE_CYCLES cycles.
  - A glitch shorter than DEBOUNCE_CYCLES leaves stable unchanged.
  - With DEBOUNCE_CYCLES=0, stable<=sync every cycle.
- Edge detect:
  - rise[i] = stable[i] & ~stable_d[i] & rise_en[i].
  - fall[i] = ~stable[i] & stable_d[i] & fall_en[i].
  - Each rise or fall event sets edge_cap[i].
- Register map (write = chipselect&write; read = chipselect&read):
  - 0 DATA_IN (RO): stable[IN_WIDTH-1:0], zero-extended.
  - 1 DATA_OUT (RW): the output register, driving pio_out directly with no output latency beyond the register.
  - 2 OUT_SET (WO): out_reg |= writedata. Reads return 0.
  - 3 OUT_CLR (WO): out_reg &= ~writedata. Reads return 0.
  - 4 IRQ_MASK (RW).
  - 5 EDGE_CAP (RW1C): writing 1 clears that bit.
  - 6 RISE_EN (RW).
  - 7 FALL_EN (RW).
- Unused upper bits read 0 and ignore writes.
- Read latency 1: readdata updates on the clock edge after the read strobe and holds its value until the next read. Reads have no side effects.
- Simultaneous edge event and W1C on the same bit in the same cycle: the event wins, so the bit stays 1.
- Changing RISE_EN/FALL_EN does not alter already-captured bits.
- irq is registered: irq <= |(edge_cap & mask), so it asserts 1 cycle after edge_cap sets and deasserts 1 cycle after a clear or mask.
- chipselect low: writes and reads are ignored, and readdata holds its value.
- A reset assertion mid-debounce discards the count, and stable returns to 0. After release, an input held high re-qualifies after the full latency.

Test Plan:
- Reset values:
  - Stimulus: OUT_RESET=10'h155; assert reset_n=0 asynchronously between edges.
  - Required: pio_out=10'h155, irq=0, and all registers read 0 except DATA_OUT=0x155, with 1-cycle read latency checked.
- Debounce qualification:
  - Stimulus: DEBOUNCE_CYCLES=8; pulse pio_in[0] high for 7 cycles, then hold it high for 8 cycles.
  - Required: the pulse leaves DATA_IN=0. The hold gives DATA_IN=0x1 exactly SYNC_STAGES+8 cycles after the rising pin edge.
- Output set/clear:
  - Stimulus: write DATA_OUT=0x0F0, then OUT_SET=0x003, then OUT_CLR=0x030.
  - Required: pio_out goes 0x0F0, then 0x0F3, then 0x0C3, each one cycle after the write.
- Edge capture and interrupt:
  - Stimulus: RISE_EN=0x1, FALL_EN=0x2, IRQ_MASK=0x1. Raise bit0 and bit1, then drop bit1.
  - Required: EDGE_CAP=0x1 after the rise, and irq rises 1 cycle later. After the bit1 fall, EDGE_CAP=0x3 and irq stays 1.
  - Stimulus: write EDGE_CAP=0x1.
  - Required: EDGE_CAP=0x2, and irq falls 1 cycle later.
- Clear/event collision:
  - Stimulus: drive a bit0 rising event in the same cycle as a W1C write of 0x1.
  - Required: EDGE_CAP bit0 remains 1.
- Bypass and reset mid-debounce:
  - Stimulus: DEBOUNCE_CYCLES=0.
  - Required: DATA_IN follows the pin after SYNC_STAGES+1 cycles.
  - Stimulus: DEBOUNCE_CYCLES=8; assert reset_n after 5 stable-high cycles, then release.
  - Required: DATA_IN=0, then 1 only after the full SYNC_STAGES+8 cycles.
